// File: rtl/chirp_seq_pkg.sv
// chirp_seq_pkg: shared encodings for the chirp frame sequencer.
// Mode codes, FSM states, ramp direction constants and mode helper.
package chirp_seq_pkg;

    localparam logic [1:0] MODE_CW  = 2'b00;
    localparam logic [1:0] MODE_SAW = 2'b01;
    localparam logic [1:0] MODE_TRI = 2'b10;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RAMP = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Saw and triangle codes ramp; 00 and 11 are both CW.
    function automatic logic is_fmcw_mode(input logic [1:0] mode);
        return (mode == MODE_SAW) || (mode == MODE_TRI);
    endfunction

endpackage

// File: rtl/chirp_ramp_gen.sv
// chirp_ramp_gen: DAC code ramp for one chirp plus the DAC latch strobe.
// Down-ramp logic is built only when CHIRP_SEQ_TRIANGLE_EN is defined.
module chirp_ramp_gen
    import chirp_seq_pkg::*;
#(
    parameter int DAC_W = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             cw_en,
`ifdef CHIRP_SEQ_TRIANGLE_EN
    input  logic             tri_en,
`endif
    input  logic [15:0]      psc,
    output logic [DAC_W-1:0] code,
    output logic             active,
    output logic             done,
    output logic             da_clk
);

    localparam logic [DAC_W-1:0] CODE_MAX = '1;

    logic [DAC_W-1:0] code_q;
    logic [DAC_W-1:0] code_nxt;
    logic [15:0]      hold_q;
    logic             active_q;
    logic             upd_q;
    logic             da_q;
    logic             step;
    logic             at_end;
`ifdef CHIRP_SEQ_TRIANGLE_EN
    logic             dir_q;
    logic             dir_nxt;
`endif

    // ">=" keeps a shrinking prescaler from stalling the ramp
    assign step   = hold_q >= psc;
    assign done   = active_q && step && at_end;
    assign code   = code_q;
    assign active = active_q;
    assign da_clk = da_q;

    // End-of-chirp detect and the next code along the ramp
    always_comb begin
        code_nxt = code_q + DAC_W'(1);
        at_end   = (code_q == CODE_MAX);
`ifdef CHIRP_SEQ_TRIANGLE_EN
        dir_nxt  = dir_q;
        if (tri_en) begin
            at_end = (dir_q == DIR_DOWN) && (code_q == '0);
            if (dir_q == DIR_DOWN) begin
                code_nxt = code_q - DAC_W'(1);
            end else if (code_q == CODE_MAX) begin
                code_nxt = CODE_MAX - DAC_W'(1);
                dir_nxt  = DIR_DOWN;
            end
        end
`endif
    end

    // Prescaler, code counter and two-stage strobe (data settles first)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_q   <= '0;
            hold_q   <= '0;
            active_q <= 1'b0;
            upd_q    <= 1'b0;
            da_q     <= 1'b0;
        end else if (abort) begin
            code_q   <= '0;
            hold_q   <= '0;
            active_q <= 1'b0;
            upd_q    <= 1'b0;
            da_q     <= 1'b0;
        end else begin
            da_q  <= upd_q;
            upd_q <= 1'b0;
            if (start) begin
                active_q <= 1'b1;
                code_q   <= '0;
                hold_q   <= '0;
                upd_q    <= 1'b1;
            end else if (active_q) begin
                if (step) begin
                    hold_q <= '0;
                    if (at_end) begin
                        active_q <= 1'b0;
                        code_q   <= '0;
                    end else begin
                        code_q <= code_nxt;
                        upd_q  <= 1'b1;
                    end
                end else begin
                    hold_q <= hold_q + 16'd1;
                end
            end else if (cw_en) begin
                if (step) begin
                    hold_q <= '0;
                    upd_q  <= 1'b1;
                end else begin
                    hold_q <= hold_q + 16'd1;
                end
            end else begin
                hold_q <= '0;
            end
        end
    end

`ifdef CHIRP_SEQ_TRIANGLE_EN
    // Direction starts up each chirp and turns at the top code
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_q <= DIR_UP;
        end else if (abort || start) begin
            dir_q <= DIR_UP;
        end else if (active_q && step && !at_end) begin
            dir_q <= dir_nxt;
        end
    end
`endif

endmodule

// File: rtl/chirp_frame_sequencer.sv
// chirp_frame_sequencer: frame timer, chirp FSM and CW/FMCW DAC output.
// Optional triangle mode: define CHIRP_SEQ_TRIANGLE_EN.
module chirp_frame_sequencer
    import chirp_seq_pkg::*;
#(
    parameter int SYS_CLK_FREQ_MHZ = 50,
    parameter int DAC_W            = 10,
    parameter int CHIRP_CNT_W      = 8,
    parameter int PERIOD_W         = 32,
    parameter int GAP_W            = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable_i,
    input  logic [1:0]             mode_i,
    input  logic [PERIOD_W-1:0]    frame_period_i,
    input  logic [CHIRP_CNT_W-1:0] chirp_num_i,
    input  logic [GAP_W-1:0]       chirp_gap_i,
    input  logic [15:0]            step_psc_i,
    input  logic [DAC_W-1:0]       cw_level_i,
    output logic [DAC_W-1:0]       vco_out_o,
    output logic                   vco_da_clk_o,
    output logic                   chirp_active_o,
    output logic [CHIRP_CNT_W-1:0] chirp_idx_o,
    output logic                   frame_start_o,
    output logic                   frame_done_o,
    output logic                   overrun_o
);

    // Clock frequency is informational only
    localparam int unused_clk_mhz = SYS_CLK_FREQ_MHZ;

    state_t               state_q;
    state_t               state_d;
    logic [CHIRP_CNT_W-1:0] idx_q;
    logic [CHIRP_CNT_W-1:0] idx_d;
    logic [GAP_W-1:0]     gap_q;
    logic [GAP_W-1:0]     gap_d;
    logic [PERIOD_W-1:0]  fcnt_q;
    logic [1:0]           mode_q;
    logic [DAC_W-1:0]     cw_q;
    logic                 cw_sel_q;
    logic                 ov_q;
    logic                 fs_q;
    logic                 fs_d;
    logic                 fd_q;
    logic                 fd_d;
    logic                 run;
    logic                 tick;
    logic                 last;
    logic                 cw_en;
    logic                 ramp_start;
    logic                 ramp_done;
    logic [DAC_W-1:0]     ramp_code;
`ifdef CHIRP_SEQ_TRIANGLE_EN
    logic                 tri_en;

    assign tri_en = (mode_q == MODE_TRI);
`endif

    assign run = enable_i && is_fmcw_mode(mode_q)
              && (frame_period_i >= PERIOD_W'(2));
    assign tick = run
               && (fcnt_q >= frame_period_i - PERIOD_W'(1));
    assign last = (chirp_num_i == '0)
               || (idx_q >= chirp_num_i - CHIRP_CNT_W'(1));
    assign cw_en = enable_i && !is_fmcw_mode(mode_q)
                && (state_q == ST_IDLE);

    assign vco_out_o     = cw_sel_q ? cw_q : ramp_code;
    assign chirp_idx_o   = idx_q;
    assign frame_start_o = fs_q;
    assign frame_done_o  = fd_q;
    assign overrun_o     = ov_q;

    // Frame period counter; held at 0 while disabled or in CW
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcnt_q <= '0;
        end else if (!run || tick) begin
            fcnt_q <= '0;
        end else begin
            fcnt_q <= fcnt_q + PERIOD_W'(1);
        end
    end

    // Chirp FSM next state, chirp index, gap count and frame pulses
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        gap_d      = gap_q;
        ramp_start = 1'b0;
        fs_d       = 1'b0;
        fd_d       = 1'b0;
        if (!enable_i) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            gap_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (tick && (chirp_num_i != '0)) begin
                        state_d    = ST_RAMP;
                        idx_d      = '0;
                        ramp_start = 1'b1;
                        fs_d       = 1'b1;
                    end
                end
                ST_RAMP: begin
                    if (ramp_done) begin
                        if (last) begin
                            state_d = ST_IDLE;
                            idx_d   = '0;
                            fd_d    = 1'b1;
                        end else if (chirp_gap_i == '0) begin
                            idx_d      = idx_q + CHIRP_CNT_W'(1);
                            ramp_start = 1'b1;
                        end else begin
                            state_d = ST_GAP;
                            gap_d   = chirp_gap_i;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_q <= GAP_W'(1)) begin
                        state_d    = ST_RAMP;
                        idx_d      = idx_q + CHIRP_CNT_W'(1);
                        ramp_start = 1'b1;
                    end else begin
                        gap_d = gap_q - GAP_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FSM registers; mode is frozen from frame start to frame end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            gap_q   <= '0;
            mode_q  <= MODE_CW;
            fs_q    <= 1'b0;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            gap_q   <= gap_d;
            fs_q    <= fs_d;
            fd_q    <= fd_d;
            if (state_q == ST_IDLE) begin
                mode_q <= mode_i;
            end
        end
    end

    // Sticky overrun on a tick mid-frame; cleared only by disable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ov_q <= 1'b0;
        end else if (!enable_i) begin
            ov_q <= 1'b0;
        end else if (tick && (state_q != ST_IDLE)) begin
            ov_q <= 1'b1;
        end
    end

    // Registered CW level and output select
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cw_sel_q <= 1'b0;
            cw_q     <= '0;
        end else begin
            cw_sel_q <= cw_en;
            cw_q     <= cw_en ? cw_level_i : '0;
        end
    end

    chirp_ramp_gen #(
        .DAC_W (DAC_W)
    ) u_ramp (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (ramp_start),
        .abort  (!enable_i),
        .cw_en  (cw_en),
`ifdef CHIRP_SEQ_TRIANGLE_EN
        .tri_en (tri_en),
`endif
        .psc    (step_psc_i),
        .code   (ramp_code),
        .active (chirp_active_o),
        .done   (ramp_done),
        .da_clk (vco_da_clk_o)
    );

endmodule

// File: tb/tb_chirp_frame_sequencer.sv
// tb_chirp_frame_sequencer: directed checks of frame timing, ramps,
// overrun, abort, CW output and degenerate settings.
module tb_chirp_frame_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [1:0]  mode = 2'b01;
    logic [31:0] period = 32'd100;
    logic [7:0]  cnum = 8'd0;
    logic [15:0] gap = 16'd0;
    logic [15:0] psc = 16'd0;
    logic [3:0]  cw_a = 4'h0;
    logic [9:0]  cw_b = 10'h0;

    logic [3:0]  vco_a;
    logic        da_a, act_a, fs_a, fd_a, ov_a;
    logic [7:0]  idx_a;
    logic [9:0]  vco_b;
    logic        da_b, act_b, fs_b, fd_b, ov_b;
    logic [7:0]  idx_b;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    chirp_frame_sequencer #(.DAC_W(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .enable_i(enable),
        .mode_i(mode), .frame_period_i(period),
        .chirp_num_i(cnum), .chirp_gap_i(gap),
        .step_psc_i(psc), .cw_level_i(cw_a),
        .vco_out_o(vco_a), .vco_da_clk_o(da_a),
        .chirp_active_o(act_a), .chirp_idx_o(idx_a),
        .frame_start_o(fs_a), .frame_done_o(fd_a),
        .overrun_o(ov_a)
    );

    chirp_frame_sequencer #(.DAC_W(10)) dut_b (
        .clk(clk), .rst_n(rst_n), .enable_i(enable),
        .mode_i(mode), .frame_period_i(period),
        .chirp_num_i(cnum), .chirp_gap_i(gap),
        .step_psc_i(psc), .cw_level_i(cw_b),
        .vco_out_o(vco_b), .vco_da_clk_o(da_b),
        .chirp_active_o(act_b), .chirp_idx_o(idx_b),
        .frame_start_o(fs_b), .frame_done_o(fd_b),
        .overrun_o(ov_b)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic setup(input logic [1:0] m, input int per,
                         input int n, input int g, input int p);
        enable = 1'b0;
        mode   = m;
        period = 32'(per);
        cnum   = 8'(n);
        gap    = 16'(g);
        psc    = 16'(p);
        cyc();
        cyc();
    endtask

    task automatic wait_fs(input int limit, output int edges);
        edges = -1;
        for (int k = 1; k <= limit; k++) begin
            cyc();
            if (fs_a === 1'b1) begin
                edges = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cyc();
        cyc();
        tests++;
        if ({vco_a, da_a, act_a, idx_a, fs_a, fd_a, ov_a} !== '0) begin
            fails++;
            $display("FAIL reset_a got %h exp 0",
                     {vco_a, da_a, act_a, idx_a, fs_a, fd_a, ov_a});
        end
        tests++;
        if ({vco_b, da_b, act_b, idx_b, fs_b, fd_b, ov_b} !== '0) begin
            fails++;
            $display("FAIL reset_b got %h exp 0",
                     {vco_b, da_b, act_b, idx_b, fs_b, fd_b, ov_b});
        end
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_saw_frame();
        int e, c, r, ev;
        logic ea;
        setup(2'b01, 100, 3, 2, 0);
        enable = 1'b1;
        wait_fs(200, e);
        tests++;
        if (e !== 100) begin
            fails++;
            $display("FAIL saw_start_edge got %0d exp 100", e);
        end
        for (int j = 0; j < 52; j++) begin
            c  = j / 18;
            r  = j % 18;
            ev = (r < 16) ? r : 0;
            ea = (r < 16);
            tests++;
            if (vco_a !== 4'(ev) || act_a !== ea || idx_a !== 8'(c)
                || fs_a !== (j == 0) || fd_a !== 1'b0) begin
                fails++;
                $display("FAIL saw_frame j=%0d vco %0d/%0d act %b/%b idx %0d/%0d fs %b fd %b",
                         j, vco_a, ev, act_a, ea, idx_a, c, fs_a, fd_a);
            end
            cyc();
        end
        tests++;
        if (fd_a !== 1'b1 || act_a !== 1'b0 || vco_a !== 4'd0
            || idx_a !== 8'd0) begin
            fails++;
            $display("FAIL saw_done got fd %b act %b vco %0d idx %0d exp 1 0 0 0",
                     fd_a, act_a, vco_a, idx_a);
        end
        cyc();
        tests++;
        if (fd_a !== 1'b0) begin
            fails++;
            $display("FAIL saw_done_pulse got %b exp 0", fd_a);
        end
    endtask

    task automatic test_overrun_abort();
        int e, c, r, ev, fs_at, fd_cnt;
        setup(2'b01, 40, 3, 2, 0);
        enable = 1'b1;
        wait_fs(100, e);
        tests++;
        if (e !== 40) begin
            fails++;
            $display("FAIL ovr_start_edge got %0d exp 40", e);
        end
        for (int j = 0; j < 52; j++) begin
            c  = j / 18;
            r  = j % 18;
            ev = (r < 16) ? r : 0;
            tests++;
            if (vco_a !== 4'(ev) || idx_a !== 8'(c)
                || ov_a !== (j >= 40) || fd_a !== 1'b0) begin
                fails++;
                $display("FAIL ovr_frame j=%0d vco %0d/%0d idx %0d/%0d ov %b fd %b",
                         j, vco_a, ev, idx_a, c, ov_a, fd_a);
            end
            cyc();
        end
        tests++;
        if (fd_a !== 1'b1 || ov_a !== 1'b1) begin
            fails++;
            $display("FAIL ovr_done got fd %b ov %b exp 1 1", fd_a, ov_a);
        end
        fs_at = -1;
        for (int j = 53; j <= 90; j++) begin
            cyc();
            if (fs_a === 1'b1) begin
                fs_at = j;
                break;
            end
        end
        tests++;
        if (fs_at !== 80) begin
            fails++;
            $display("FAIL ovr_next_start got %0d exp 80", fs_at);
        end
        repeat (25) cyc();
        tests++;
        if (vco_a !== 4'd7 || idx_a !== 8'd1 || ov_a !== 1'b1) begin
            fails++;
            $display("FAIL abort_pre got vco %0d idx %0d ov %b exp 7 1 1",
                     vco_a, idx_a, ov_a);
        end
        enable = 1'b0;
        cyc();
        tests++;
        if (vco_a !== 4'd0 || idx_a !== 8'd0 || ov_a !== 1'b0
            || act_a !== 1'b0 || fd_a !== 1'b0) begin
            fails++;
            $display("FAIL abort got vco %0d idx %0d ov %b act %b fd %b exp 0",
                     vco_a, idx_a, ov_a, act_a, fd_a);
        end
        fd_cnt = 0;
        repeat (30) begin
            cyc();
            if (fd_a === 1'b1) fd_cnt++;
        end
        tests++;
        if (fd_cnt !== 0) begin
            fails++;
            $display("FAIL abort_no_done got %0d exp 0", fd_cnt);
        end
    endtask

    task automatic test_triangle();
        int e, k, ev, len;
`ifdef CHIRP_SEQ_TRIANGLE_EN
        len = 62;
`else
        len = 32;
`endif
        setup(2'b10, 200, 1, 0, 1);
        enable = 1'b1;
        wait_fs(300, e);
        tests++;
        if (e !== 200) begin
            fails++;
            $display("FAIL tri_start_edge got %0d exp 200", e);
        end
        for (int j = 0; j < len; j++) begin
            k  = j / 2;
            ev = (k <= 15) ? k : 30 - k;
            tests++;
            if (vco_a !== 4'(ev) || act_a !== 1'b1 || fd_a !== 1'b0) begin
                fails++;
                $display("FAIL tri_ramp j=%0d vco %0d/%0d act %b fd %b",
                         j, vco_a, ev, act_a, fd_a);
            end
            cyc();
        end
        tests++;
        if (fd_a !== 1'b1 || act_a !== 1'b0) begin
            fails++;
            $display("FAIL tri_done len %0d got fd %b act %b exp 1 0",
                     len, fd_a, act_a);
        end
    endtask

    task automatic test_cw();
        int nstb, prev, bad_gap, nfs;
        setup(2'b00, 20, 3, 0, 3);
        cw_a   = 4'h5;
        cw_b   = 10'h2A5;
        enable = 1'b1;
        repeat (3) cyc();
        tests++;
        if (vco_b !== 10'h2A5 || vco_a !== 4'h5) begin
            fails++;
            $display("FAIL cw_level got %h/%h exp 2a5/5", vco_b, vco_a);
        end
        nstb = 0;
        prev = -1;
        bad_gap = 0;
        nfs = 0;
        for (int j = 0; j < 60; j++) begin
            cyc();
            if (da_b === 1'b1) begin
                nstb++;
                if (prev >= 0 && j - prev != 4) bad_gap++;
                prev = j;
            end
            if (fs_a === 1'b1 || fs_b === 1'b1) nfs++;
            if (fd_a === 1'b1 || fd_b === 1'b1) nfs++;
        end
        tests++;
        if (nstb !== 15 || bad_gap !== 0) begin
            fails++;
            $display("FAIL cw_strobe got %0d strobes %0d bad gaps exp 15 0",
                     nstb, bad_gap);
        end
        tests++;
        if (nfs !== 0) begin
            fails++;
            $display("FAIL cw_no_frame got %0d pulses exp 0", nfs);
        end
        tests++;
        if (vco_b !== 10'h2A5) begin
            fails++;
            $display("FAIL cw_hold got %h exp 2a5", vco_b);
        end
        cw_a = 4'h0;
        cw_b = 10'h0;
    endtask

    task automatic test_no_frame();
        int nfs, nz;
        for (int s = 0; s < 2; s++) begin
            if (s == 0) setup(2'b01, 10, 0, 2, 0);
            else        setup(2'b01, 1, 3, 2, 0);
            enable = 1'b1;
            nfs = 0;
            nz  = 0;
            repeat (60) begin
                cyc();
                if (fs_a === 1'b1) nfs++;
                if (vco_a !== 4'd0 || act_a !== 1'b0) nz++;
            end
            tests++;
            if (nfs !== 0 || nz !== 0) begin
                fails++;
                $display("FAIL no_frame case %0d got %0d starts %0d active exp 0 0",
                         s, nfs, nz);
            end
        end
    endtask

    task automatic test_back_to_back();
        int e;
        setup(2'b01, 100, 2, 0, 0);
        enable = 1'b1;
        wait_fs(200, e);
        tests++;
        if (e !== 100) begin
            fails++;
            $display("FAIL b2b_start_edge got %0d exp 100", e);
        end
        for (int j = 0; j < 32; j++) begin
            tests++;
            if (vco_a !== 4'(j % 16) || idx_a !== 8'(j / 16)
                || act_a !== 1'b1) begin
                fails++;
                $display("FAIL b2b j=%0d vco %0d/%0d idx %0d/%0d act %b",
                         j, vco_a, j % 16, idx_a, j / 16, act_a);
            end
            cyc();
        end
        tests++;
        if (fd_a !== 1'b1 || act_a !== 1'b0) begin
            fails++;
            $display("FAIL b2b_done got fd %b act %b exp 1 0", fd_a, act_a);
        end
    endtask

    initial begin
        test_reset();
        test_saw_frame();
        test_overrun_abort();
        test_triangle();
        test_cw();
        test_no_frame();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule

// File: doc/chirp_frame_sequencer.md
# chirp_frame_sequencer

Parametrised frame/chirp sequencer driving the VCO tuning DAC for the radar front end. Periodically launches frames of N chirps with a programmable inter-chirp gap, supports CW, sawtooth-FMCW and triangle-FMCW modes, and reports frame boundaries and overruns to the sampling/DSP side. Generates the DAC sample stream and DAC latch clock through one ramp sub-module.

## Interface
- SYS_CLK_FREQ_MHZ, 50, system clock frequency (documentation/derived constants only)
- DAC_W, 10, VCO DAC width; ramp spans 0..2^DAC_W-1
- CHIRP_CNT_W, 8, width of chirp count and index
- PERIOD_W, 32, width of frame period counter
- GAP_W, 16, width of inter-chirp gap counter
- clk  in  1  system clock, all logic rising-edge
- rst_n  in  1  asynchronous active-low reset
- enable_i  in  1  run enable; low aborts immediately
- mode_i  in  2  00 CW, 01 sawtooth, 10 triangle, 11 = CW
- frame_period_i  in  PERIOD_W  frame period in clk cycles
- chirp_num_i  in  CHIRP_CNT_W  chirps per frame
- chirp_gap_i  in  GAP_W  idle cycles between chirps
- step_psc_i  in  16  ramp step prescaler; sample held step_psc_i+1 cycles
- cw_level_i  in  DAC_W  DAC code in CW mode
- vco_out_o  out  DAC_W  DAC code
- vco_da_clk_o  out  1  DAC latch strobe
- chirp_active_o  out  1  high while ramping
- chirp_idx_o  out  CHIRP_CNT_W  index of current chirp
- frame_start_o  out  1  one-cycle pulse at frame start
- frame_done_o  out  1  one-cycle pulse after last chirp
- overrun_o  out  1  sticky: frame tick arrived while frame still running

## Operation
- Reset: all outputs 0, state IDLE, counters 0.
- Frame counter runs when enable_i=1 and latched mode is FMCW; counts 0..frame_period_i-1, tick at period-1, wraps to 0. frame_period_i<2: no ticks. enable_i=0 or CW: counter held at 0.
- States IDLE, RAMP, GAP.
- IDLE: on tick with chirp_num_i!=0 -> RAMP, chirp_idx_o=0, frame_start_o pulse, mode_i latched for the frame. chirp_num_i=0: ticks ignored.
- RAMP: ramp sub-module triggered; on ramp done: if chirp_idx_o==chirp_num_i-1 -> IDLE with frame_done_o pulse; else if chirp_gap_i==0 -> RAMP again with idx+1; else GAP, gap counter loaded with chirp_gap_i.
- GAP: count down; on reaching 1 -> RAMP, idx+1. Output 0 in GAP/IDLE.
- Sawtooth chirp: codes 0,1,..,2^DAC_W-1, each held step_psc_i+1 cycles; done when last hold ends.
- Triangle chirp: 0 up to MAX then MAX-1 down to 0; done when final 0 hold ends (one chirp = up+down).
- CW: vco_out_o = cw_level_i (registered), state forced IDLE, da strobe continues at step rate.
- Tick while not IDLE: tick ignored, overrun_o set; cleared only by enable_i=0 or reset.
- enable_i falling: next cycle state IDLE, idx 0, vco_out_o 0, ramp sub-module aborted, no frame_done_o.
- Input changes to chirp_num_i/gap/psc mid-frame take effect at the next comparison; mode_i only at frame start.

## Timing
- Tick at cycle T -> state RAMP, frame_start_o and chirp_active_o high at T+1; first code 0 on vco_out_o at T+1.
- vco_da_clk_o: one-cycle pulse the cycle after each vco_out_o update (data stable one full cycle before strobe).
- Sawtooth chirp length 2^DAC_W*(step_psc_i+1) cycles; triangle (2^(DAC_W+1)-1)*(step_psc_i+1).
- frame_done_o in the cycle state returns to IDLE; frame_start_o may follow on the very next tick.

## Configuration
- CHIRP_SEQ_TRIANGLE_EN: defined -> mode 10 is triangle as above. Undefined -> mode 10 behaves as sawtooth and the down-ramp logic is not built.

## Structure
- Package chirp_seq_pkg: mode encodings (MODE_CW, MODE_SAW, MODE_TRI), state encoding enum, ramp direction constants.
- Sub-module chirp_ramp_gen: prescaler, code counter, direction, trigger/abort in, done pulse and DAC strobe out.

## Test plan
- DAC_W=4, psc=0, period=100, chirps=3, gap=2, sawtooth -> frame_start at T+1, three 16-cycle ramps separated by 2 zero cycles, frame_done, idx 0,1,2.
- Same with period=40 -> overrun_o sets at second tick, frame completes normally, next frame starts on following tick.
- Triangle, DAC_W=4, psc=1 -> 0..15..0, 62 cycles per chirp; without CHIRP_SEQ_TRIANGLE_EN -> 32-cycle sawtooth.
- CW, cw_level=0x2A5, psc=3 -> vco_out_o=0x2A5, vco_da_clk_o pulse every 4 cycles, no frame pulses.
- enable_i dropped mid-ramp of chirp 1 -> next cycle vco_out_o=0, idx=0, no frame_done; overrun cleared.
- chirp_num=0 or period=1 -> no frame_start ever; gap=0 -> chirps back-to-back.
